// File: rtl/fpgaminer_regs.sv
// Avalon-MM register block for the bitcoin miner core: work inputs, nonce search
// control/counter and golden-nonce capture.
module fpgaminer_regs #(
  parameter logic [31:0] ID_VALUE = 32'h4D494E45
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   avs_s0_address,
  input  logic         avs_s0_write,
  input  logic [31:0]  avs_s0_writedata,
  input  logic [3:0]   avs_s0_byteenable,
  input  logic         avs_s0_read,
  output logic [31:0]  avs_s0_readdata,
  output logic [255:0] midstate,
  output logic [95:0]  data,
  output logic [31:0]  nonce,
  output logic         running,
  input  logic         golden_valid,
  input  logic [31:0]  golden_nonce_in
);

  localparam int unsigned WORD_W    = 32;
  localparam logic [3:0]  W_DATA2   = 4'd10;
  localparam logic [3:0]  W_CONTROL = 4'd11;
  localparam logic [3:0]  W_STATUS  = 4'd12;
  localparam logic [3:0]  W_NONCE   = 4'd13;
  localparam logic [3:0]  W_GOLDEN  = 4'd14;
  localparam logic [3:0]  W_ID      = 4'd15;

  logic [3:0]        word;
  logic [1:0]        unused_addr;
  logic [WORD_W-1:0] golden;
  logic              found;
  logic              exhausted;

  logic [WORD_W-1:0] nonce_d;
  logic [WORD_W-1:0] golden_d;
  logic              running_d;
  logic              found_d;
  logic              exhausted_d;
  logic [WORD_W-1:0] rd_c;

  logic              ctrl_wr;
  logic              stat_wr;

  assign word        = avs_s0_address[5:2];
  assign unused_addr = avs_s0_address[1:0];
  assign ctrl_wr     = avs_s0_write && (word == W_CONTROL) && avs_s0_byteenable[0];
  assign stat_wr     = avs_s0_write && (word == W_STATUS) && avs_s0_byteenable[0];

  function automatic logic [WORD_W-1:0] merge_bytes(input logic [WORD_W-1:0] old_v,
                                                    input logic [WORD_W-1:0] new_v,
                                                    input logic [3:0]        be);
    logic [WORD_W-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  // Search control: clears apply first so same-cycle sets (hit, wrap) win.
  always_comb begin
    nonce_d     = nonce;
    golden_d    = golden;
    running_d   = running;
    found_d     = found;
    exhausted_d = exhausted;

    if (stat_wr) begin
      if (avs_s0_writedata[1]) found_d = 1'b0;
      if (avs_s0_writedata[2]) exhausted_d = 1'b0;
    end

    if (golden_valid && running) begin
      golden_d = golden_nonce_in;
      found_d  = 1'b1;
    end

    if (running) begin
      if (ctrl_wr && avs_s0_writedata[1]) begin
        running_d = 1'b0;
      end else if (nonce == '1) begin
        nonce_d     = '0;
        running_d   = 1'b0;
        exhausted_d = 1'b1;
      end else begin
        nonce_d = nonce + WORD_W'(1);
      end
    end else begin
      if (ctrl_wr && avs_s0_writedata[0] && !avs_s0_writedata[1]) running_d = 1'b1;
      if (avs_s0_write && (word == W_NONCE))
        nonce_d = merge_bytes(nonce, avs_s0_writedata, avs_s0_byteenable);
    end
  end

  // Read mux reflects register contents before any same-edge update.
  always_comb begin
    rd_c = '0;
    if (!word[3]) begin
      rd_c = midstate[{word[2:0], 5'd0} +: WORD_W];
    end else if (word <= W_DATA2) begin
      rd_c = data[{word[1:0], 5'd0} +: WORD_W];
    end else begin
      case (word)
        W_CONTROL: rd_c = {30'd0, running, 1'b0};
        W_STATUS:  rd_c = {29'd0, exhausted, found, running};
        W_NONCE:   rd_c = nonce;
        W_GOLDEN:  rd_c = golden;
        W_ID:      rd_c = ID_VALUE;
        default:   rd_c = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      midstate        <= '0;
      data            <= '0;
      nonce           <= '0;
      golden          <= '0;
      running         <= 1'b0;
      found           <= 1'b0;
      exhausted       <= 1'b0;
      avs_s0_readdata <= '0;
    end else begin
      if (avs_s0_write && !word[3]) begin
        midstate[{word[2:0], 5'd0} +: WORD_W] <=
          merge_bytes(midstate[{word[2:0], 5'd0} +: WORD_W], avs_s0_writedata, avs_s0_byteenable);
      end
      if (avs_s0_write && word[3] && (word <= W_DATA2)) begin
        data[{word[1:0], 5'd0} +: WORD_W] <=
          merge_bytes(data[{word[1:0], 5'd0} +: WORD_W], avs_s0_writedata, avs_s0_byteenable);
      end
      nonce     <= nonce_d;
      golden    <= golden_d;
      running   <= running_d;
      found     <= found_d;
      exhausted <= exhausted_d;
      if (avs_s0_read) avs_s0_readdata <= rd_c;
    end
  end

endmodule

// File: tb/tb_fpgaminer_regs.sv
// Self-checking bench for fpgaminer_regs: directed scenarios plus random bus traffic
// compared cycle by cycle against a register-map level reference model.
module tb_fpgaminer_regs;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [5:0]   addr = '0;
  logic         wr = 1'b0;
  logic [31:0]  wdata = '0;
  logic [3:0]   be = '0;
  logic         rd = 1'b0;
  logic [31:0]  rdata;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [31:0]  nonce;
  logic         running;
  logic         gv = 1'b0;
  logic [31:0]  gn = '0;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, one entry per architectural register.
  logic [31:0] m_mid [8];
  logic [31:0] m_dat [3];
  logic [31:0] m_nonce, m_golden, m_rd;
  logic        m_run, m_found, m_exh;

  fpgaminer_regs dut (
    .clk               (clk),
    .reset             (reset),
    .avs_s0_address    (addr),
    .avs_s0_write      (wr),
    .avs_s0_writedata  (wdata),
    .avs_s0_byteenable (be),
    .avs_s0_read       (rd),
    .avs_s0_readdata   (rdata),
    .midstate          (midstate),
    .data              (data),
    .nonce             (nonce),
    .running           (running),
    .golden_valid      (gv),
    .golden_nonce_in   (gn)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] apply_be(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] e);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (e[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input int w);
    if (w < 8)  return m_mid[w];
    if (w < 11) return m_dat[w-8];
    case (w)
      11: return {30'd0, m_run, 1'b0};
      12: return {29'd0, m_exh, m_found, m_run};
      13: return m_nonce;
      14: return m_golden;
      default: return 32'h4D494E45;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently on the bus.
  task automatic model_step();
    int  w;
    bit  was_run, stop, start;
    w = int'(addr) / 4;
    if (reset) begin
      foreach (m_mid[i]) m_mid[i] = '0;
      foreach (m_dat[i]) m_dat[i] = '0;
      m_nonce = '0; m_golden = '0; m_rd = '0;
      m_run = 0; m_found = 0; m_exh = 0;
      return;
    end
    if (rd) m_rd = model_read(w);
    was_run = m_run;
    stop  = wr && w == 11 && be[0] && wdata[1];
    start = wr && w == 11 && be[0] && wdata[0] && !stop;
    if (wr && w < 8)  m_mid[w]   = apply_be(m_mid[w], wdata, be);
    if (wr && w >= 8 && w < 11) m_dat[w-8] = apply_be(m_dat[w-8], wdata, be);
    if (wr && w == 12 && be[0] && wdata[1]) m_found = 0;
    if (wr && w == 12 && be[0] && wdata[2]) m_exh = 0;
    if (gv && was_run) begin m_golden = gn; m_found = 1; end
    if (was_run) begin
      if (stop) m_run = 0;
      else if (m_nonce == 32'hFFFF_FFFF) begin m_nonce = 0; m_run = 0; m_exh = 1; end
      else m_nonce = m_nonce + 1;
    end else begin
      if (start) m_run = 1;
      if (wr && w == 13) m_nonce = apply_be(m_nonce, wdata, be);
    end
  endtask

  task automatic tick();
    logic [255:0] em;
    logic [95:0]  ed;
    model_step();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) em[32*i +: 32] = m_mid[i];
    for (int i = 0; i < 3; i++) ed[32*i +: 32] = m_dat[i];
    check("midstate", midstate, em);
    check("data", {160'd0, data}, {160'd0, ed});
    check("nonce", {224'd0, nonce}, {224'd0, m_nonce});
    check("running", {255'd0, running}, {255'd0, m_run});
    check("readdata", {224'd0, rdata}, {224'd0, m_rd});
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] e);
    addr = a; wdata = d; be = e; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] v);
    addr = a; rd = 1'b1;
    tick();
    rd = 1'b0;
    v = rdata;
  endtask

  task automatic pulse_golden(input logic [31:0] v);
    gv = 1'b1; gn = v;
    tick();
    gv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  initial begin
    logic [31:0]  v, frozen;
    logic [255:0] exp_ms;

    reset = 1'b1; tick(); tick(); reset = 1'b0;
    check("rst_readdata", {224'd0, rdata}, 256'd0);
    check("rst_running", {255'd0, running}, 256'd0);
    check("rst_midstate", midstate, 256'd0);

    for (int i = 0; i < 8; i++) bus_wr(6'(i*4), 32'(i), 4'hF);
    idle(20);
    exp_ms = '0;
    for (int i = 0; i < 8; i++) exp_ms[32*i +: 32] = 32'(i);
    check("midstate_load", midstate, exp_ms);
    bus_rd(6'h0C, v);
    check("rd_mid3", {224'd0, v}, 256'h3);

    bus_rd(6'h3C, v);
    check("rd_id", {224'd0, v}, 256'h4D494E45);
    bus_wr(6'h20, 32'h12345678, 4'b0010);
    bus_rd(6'h20, v);
    check("data0_be", {224'd0, v}, 256'h00005600);

    bus_wr(6'h34, 32'h100, 4'hF);
    bus_wr(6'h2C, 32'h1, 4'hF);
    idle(10);
    check("nonce_range", {255'd0, (nonce >= 32'h109 && nonce <= 32'h10B)}, 256'd1);
    bus_rd(6'h30, v);
    check("status_run", {255'd0, v[0]}, 256'd1);
    bus_wr(6'h2C, 32'h2, 4'hF);
    frozen = nonce;
    idle(5);
    check("nonce_frozen", {224'd0, nonce}, {224'd0, frozen});

    bus_wr(6'h2C, 32'h1, 4'hF);
    pulse_golden(32'hDEADBEEF);
    bus_rd(6'h38, v);
    check("golden1", {224'd0, v}, 256'hDEADBEEF);
    bus_rd(6'h30, v);
    check("found_set", {255'd0, v[1]}, 256'd1);
    bus_wr(6'h30, 32'h2, 4'hF);
    bus_rd(6'h30, v);
    check("found_clr", {255'd0, v[1]}, 256'd0);
    pulse_golden(32'hCAFEF00D);
    bus_rd(6'h38, v);
    check("golden2", {224'd0, v}, 256'hCAFEF00D);
    bus_wr(6'h2C, 32'h2, 4'hF);
    pulse_golden(32'h11111111);
    bus_rd(6'h38, v);
    check("golden_idle_ignored", {224'd0, v}, 256'hCAFEF00D);

    bus_wr(6'h34, 32'hFFFF_FFFD, 4'hF);
    bus_wr(6'h2C, 32'h1, 4'hF);
    bus_wr(6'h34, 32'h55, 4'hF);
    check("nonce_wr_ignored", {224'd0, nonce}, 256'hFFFF_FFFE);
    idle(3);
    check("wrap_running", {255'd0, running}, 256'd0);
    check("wrap_nonce", {224'd0, nonce}, 256'd0);
    bus_rd(6'h30, v);
    check("exhausted", {255'd0, v[2]}, 256'd1);

    bus_wr(6'h34, 32'h1000, 4'hF);
    bus_wr(6'h2C, 32'h1, 4'hF);
    idle(3);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_nonce", {224'd0, nonce}, 256'd0);
    check("mid_rst_running", {255'd0, running}, 256'd0);
    check("mid_rst_data", {160'd0, data}, 256'd0);
    bus_rd(6'h38, v);
    check("mid_rst_golden", {224'd0, v}, 256'd0);

    // Random traffic; nonce loads are biased near the top so wraps occur.
    for (int k = 0; k < 600; k++) begin
      addr  = 6'($urandom);
      wdata = $urandom;
      be    = 4'($urandom);
      wr    = ($urandom_range(0, 2) == 0);
      rd    = ($urandom_range(0, 1) == 0);
      gv    = ($urandom_range(0, 7) == 0);
      gn    = $urandom;
      if (wr && addr[5:2] == 4'd13 && $urandom_range(0, 1) == 0) begin
        wdata = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)); be = 4'hF;
      end
      if (wr && addr[5:2] == 4'd11 && $urandom_range(0, 2) != 0) begin
        wdata = 32'h1; be = 4'hF;
      end
      tick();
    end
    wr = 1'b0; rd = 1'b0; gv = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpgaminer_regs.md
# fpgaminer_regs

Avalon-MM slave register block for the FPGA bitcoin miner core, exposed as component slave `s0`. The host uses it to load the SHA-256 midstate and the last 96 bits of block data, start and stop nonce search, and read back status and the golden nonce. It drives the hashing pipeline's work inputs and nonce counter, and it captures golden-nonce reports from that pipeline. It contains no SHA-256 logic.

## Interface
Parameters:
- `ID_VALUE`, default 32'h4D494E45: constant returned by the ID register.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `avs_s0_address` in 6: byte address.
  - Word select is [5:2]; bits [1:0] are ignored.
- `avs_s0_write` in 1: write strobe.
- `avs_s0_writedata` in 32: write data.
- `avs_s0_byteenable` in 4: per-byte write enable.
- `avs_s0_read` in 1: read strobe.
- `avs_s0_readdata` out 32: read data, fixed read latency of 1.
- `midstate` out 256: word k is at bits [32k+31:32k].
- `data` out 96: word k is at bits [32k+31:32k].
- `nonce` out 32: current nonce presented to the hasher.
- `running` out 1: the search is active.
- `golden_valid` in 1: hasher reports a hit. It is one-cycle qualified.
- `golden_nonce_in` in 32: nonce that produced the hit.

## Operation
Register map, by word index:
- 0–7 `MIDSTATE[0..7]`: read/write, byte-enabled.
- 8–10 `DATA[0..2]`: read/write, byte-enabled.
- 11 `CONTROL`:
  - Write bit0=1: start, which sets running.
  - Write bit1=1: stop, which clears running.
  - If both bits are 1, stop wins.
  - Reads return {30'b0, running, 1'b0}.
- 12 `STATUS`:
  - bit0 = running.
  - bit1 = found (sticky).
  - bit2 = exhausted (sticky).
  - Writing 1 to bit1 or bit2 clears that bit.
- 13 `NONCE`:
  - Reads return the current nonce.
  - Writes load a start value only while not running; writes while running are ignored.
  - Byte enables apply.
- 14 `GOLDEN`: read-only, last captured golden nonce.
- 15 `ID`: read-only, `ID_VALUE`.

Write behaviour:
- A byte is written only where its `avs_s0_byteenable` bit is 1.
- Writes to read-only registers have no effect.

Nonce counter:
- While running, `nonce` increments by 1 every cycle, including the cycle in which running is first seen high.
- If `nonce` is 32'hFFFFFFFF while running, it wraps to 0, running clears, and exhausted sets.

Golden capture:
- When `golden_valid`=1 and running=1: GOLDEN <= `golden_nonce_in` and found <= 1.
- A later hit overwrites GOLDEN; found stays 1.
- `golden_valid` while not running is ignored.
- A host write to CONTROL does not clear found.

Reset values (`reset`=1):
- All MIDSTATE, DATA, NONCE and GOLDEN registers are 0.
- running, found and exhausted are 0.
- `avs_s0_readdata` is 0.
- Reset mid-search returns everything to these values on the next edge.

## Timing
- Writes take effect at the clock edge where `avs_s0_write`=1. The new value is visible on `midstate`/`data`/`nonce` in the following cycle.
- No wait states; `waitrequest` is not implemented.
- Read: `avs_s0_readdata` is valid on the cycle after `avs_s0_read` and holds until the next read.
- Start written at edge N: running=1 after edge N, and nonce has first incremented after edge N+1.
- Stop: running=0 after the write edge, and nonce holds its value.
- Simultaneous events in the same cycle:
  - Host clear of found with `golden_valid`: set wins, found stays 1.
  - Host clear of exhausted with a wrap: exhausted stays 1.
  - NONCE write with the start write: not possible in one cycle, since there is one bus.
- A read of STATUS returns the value present at the read edge, before any same-edge update.

## Test plan
- After reset release, write data i to byte address i*4 for i=0..7, then wait 20 cycles:
  - `midstate` = {32'h7,32'h6,...,32'h0}.
  - Reading MIDSTATE[3] returns 3 one cycle after the read.
- Read ID (address 0x3C) returns 32'h4D494E45. Write 0x12345678 with byteenable 4'b0010 to DATA[0]; readback is 0x00005600.
- Write NONCE=0x100, then start (CONTROL=1) and wait 10 cycles:
  - STATUS bit0=1.
  - NONCE is in the range 0x109–0x10B.
  - After a stop write, nonce is frozen across 5 cycles.
- While running, pulse `golden_valid` with `golden_nonce_in`=0xDEADBEEF:
  - GOLDEN=0xDEADBEEF and STATUS bit1=1.
  - Writing STATUS=2 clears it.
  - A second pulse with 0xCAFEF00D overwrites GOLDEN.
- Write NONCE=0xFFFFFFFD and start:
  - After the wrap, running=0, nonce=0 and STATUS bit2=1.
  - A NONCE write while running is ignored.
- Assert `reset` mid-search: after one edge, all outputs and registers are 0 and running=0.
